// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch resolution bus: resolve inputs, fetch-side BHT lookup,
// and the redirect / statistics outputs of branch_resolve_unit.
interface branch_resolve_unit_if;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_br_target;
    logic [31:0] ex_jalr_target;
    logic        ex_pred_taken;
    logic        br_eq;
    logic        br_lt;
    logic        br_ltu;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    // Pipeline side: drives EX/IF information, observes redirect and stats
    modport master (
        output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
               ex_pc, ex_br_target, ex_jalr_target, ex_pred_taken,
               br_eq, br_lt, br_ltu, if_pc,
        input  if_pred_taken, redirect_valid, redirect_pc,
               branch_count, mispredict_count
    );

    // Resolve unit side
    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
               ex_pc, ex_br_target, ex_jalr_target, ex_pred_taken,
               br_eq, br_lt, br_ltu, if_pc,
        output if_pred_taken, redirect_valid, redirect_pc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves B-type/JAL/JALR in EX, issues a registered
// one-cycle redirect on mispredict or jump, and owns the 2-bit BHT read by fetch.
module branch_resolve_unit #(
    parameter int unsigned BHT_IDX_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    branch_resolve_unit_if.slave bus
);
    localparam int unsigned BHT_SIZE = 1 << BHT_IDX_W;

    logic [1:0]           bht [BHT_SIZE];
    logic [BHT_IDX_W-1:0] ex_idx;
    logic [BHT_IDX_W-1:0] if_idx;
    logic                 act;
    logic                 do_jalr;
    logic                 do_jal;
    logic                 br_legal;
    logic                 br_taken;
    logic                 do_branch;
    logic                 mispredict;
    logic                 redirect_next;
    logic [31:0]          redirect_pc_next;
    logic [1:0]           bht_cur;
    logic [1:0]           bht_next;
    logic                 unused_bits;

    assign ex_idx = bus.ex_pc[BHT_IDX_W+1:2];
    assign if_idx = bus.if_pc[BHT_IDX_W+1:2];
    assign unused_bits = ^{bus.if_pc[31:BHT_IDX_W+2], bus.if_pc[1:0],
                           bus.ex_jalr_target[0]};

    // Fetch-side prediction: plain read of the table, no same-cycle bypass
    always_comb begin
        bus.if_pred_taken = bht[if_idx][1];
    end

    // funct3 decode of the comparator flags
    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        unique case (bus.ex_funct3)
            3'b000:  br_taken = bus.br_eq;
            3'b001:  br_taken = ~bus.br_eq;
            3'b100:  br_taken = bus.br_lt;
            3'b101:  br_taken = ~bus.br_lt;
            3'b110:  br_taken = bus.br_ltu;
            3'b111:  br_taken = ~bus.br_ltu;
            default: br_legal = 1'b0;
        endcase
    end

    // Instruction classification with jalr > jal > branch priority; a live
    // redirect squashes the wrong-path EX instruction
    always_comb begin
        act        = bus.ex_valid & ~bus.redirect_valid & ~rst;
        do_jalr    = act & bus.ex_is_jalr;
        do_jal     = act & ~bus.ex_is_jalr & bus.ex_is_jal;
        do_branch  = act & ~bus.ex_is_jalr & ~bus.ex_is_jal & bus.ex_is_branch & br_legal;
        mispredict = do_branch & (br_taken != bus.ex_pred_taken);
    end

    // Redirect target selection
    always_comb begin
        redirect_next    = do_jalr | do_jal | mispredict;
        redirect_pc_next = bus.redirect_pc;
        if (do_jalr)
            redirect_pc_next = {bus.ex_jalr_target[31:1], 1'b0};
        else if (do_jal)
            redirect_pc_next = bus.ex_br_target;
        else if (mispredict)
            redirect_pc_next = br_taken ? bus.ex_br_target : bus.ex_pc + 32'd4;
    end

    // Saturating 2-bit counter step for the resolving branch's entry
    always_comb begin
        bht_cur  = bht[ex_idx];
        bht_next = bht_cur;
        if (br_taken) begin
            if (bht_cur != 2'b11) bht_next = bht_cur + 2'd1;
        end else begin
            if (bht_cur != 2'b00) bht_next = bht_cur - 2'd1;
        end
    end

    // Redirect register: one-cycle pulse, target held between redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
        end else begin
            bus.redirect_valid <= redirect_next;
            bus.redirect_pc    <= redirect_pc_next;
        end
    end

    // Branch and mispredict statistics, wrapping at 2**32
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.branch_count     <= '0;
            bus.mispredict_count <= '0;
        end else begin
            if (do_branch)  bus.branch_count     <= bus.branch_count + 32'd1;
            if (mispredict) bus.mispredict_count <= bus.mispredict_count + 32'd1;
        end
    end

    // BHT: reset to weakly not-taken, trained by legal active branches
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_SIZE; i++)
                bht[i] <= 2'b01;
        end else if (do_branch) begin
            bht[ex_idx] <= bht_next;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    branch_resolve_unit_if bus ();

    branch_resolve_unit #(.BHT_IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int          m_bht [16];
    bit          m_init = 1'b0;
    bit          m_rv;
    logic [31:0] m_rpc;
    logic [31:0] m_bc;
    logic [31:0] m_mc;
    // Model state for after the coming edge
    int          n_bht [16];
    bit          n_rv;
    logic [31:0] n_rpc;
    logic [31:0] n_bc;
    logic [31:0] n_mc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit br, input bit jal, input bit jalr,
                         input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [31:0] jt,
                         input bit pred, input bit eq, input bit lt, input bit ltu);
        bus.ex_valid       = v;
        bus.ex_is_branch   = br;
        bus.ex_is_jal      = jal;
        bus.ex_is_jalr     = jalr;
        bus.ex_funct3      = f3;
        bus.ex_pc          = pc;
        bus.ex_br_target   = tgt;
        bus.ex_jalr_target = jt;
        bus.ex_pred_taken  = pred;
        bus.br_eq          = eq;
        bus.br_lt          = lt;
        bus.br_ltu         = ltu;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    endtask

    // Reference: what the spec says the edge should do to the visible state
    task automatic model_next();
        bit legal, taken;
        int idx;
        n_bht = m_bht;
        n_rv = m_rv; n_rpc = m_rpc; n_bc = m_bc; n_mc = m_mc;
        if (rst) begin
            foreach (n_bht[i]) n_bht[i] = 1;
            n_rv = 0; n_rpc = 0; n_bc = 0; n_mc = 0;
            return;
        end
        n_rv = 0;
        if (!bus.ex_valid || m_rv) return;
        if (bus.ex_is_jalr) begin
            n_rv = 1;
            n_rpc = bus.ex_jalr_target & 32'hFFFF_FFFE;
        end else if (bus.ex_is_jal) begin
            n_rv = 1;
            n_rpc = bus.ex_br_target;
        end else if (bus.ex_is_branch) begin
            legal = 1; taken = 0;
            case (bus.ex_funct3)
                3'd0: taken = bus.br_eq;
                3'd1: taken = !bus.br_eq;
                3'd4: taken = bus.br_lt;
                3'd5: taken = !bus.br_lt;
                3'd6: taken = bus.br_ltu;
                3'd7: taken = !bus.br_ltu;
                default: legal = 0;
            endcase
            if (legal) begin
                idx = int'((bus.ex_pc >> 2) % 16);
                n_bht[idx] = taken ? ((m_bht[idx] + 1 > 3) ? 3 : m_bht[idx] + 1)
                                   : ((m_bht[idx] - 1 < 0) ? 0 : m_bht[idx] - 1);
                n_bc = m_bc + 1;
                if (taken != bus.ex_pred_taken) begin
                    n_mc = m_mc + 1;
                    n_rv = 1;
                    n_rpc = taken ? bus.ex_br_target : bus.ex_pc + 32'd4;
                end
            end
        end
    endtask

    // One clock: check the combinational prediction mid-cycle, then the
    // registered outputs just after the edge
    task automatic cycle();
        @(negedge clk);
        if (m_init)
            check("if_pred_taken", {31'b0, bus.if_pred_taken},
                  (m_bht[int'((bus.if_pc >> 2) % 16)] >= 2) ? 32'd1 : 32'd0);
        model_next();
        @(posedge clk);
        #1;
        if (rst) m_init = 1'b1;
        m_bht = n_bht; m_rv = n_rv; m_rpc = n_rpc; m_bc = n_bc; m_mc = n_mc;
        if (m_init) begin
            check("redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, m_rv});
            check("redirect_pc", bus.redirect_pc, m_rpc);
            check("branch_count", bus.branch_count, m_bc);
            check("mispredict_count", bus.mispredict_count, m_mc);
        end
    endtask

    initial begin
        idle();
        bus.if_pc = 32'h40;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        #1;
        check("rst_pred", {31'b0, bus.if_pred_taken}, 32'd0);
        check("rst_bc", bus.branch_count, 32'd0);
        check("rst_rv", {31'b0, bus.redirect_valid}, 32'd0);
        cycle();

        // BEQ taken, predicted not-taken
        drive(1, 1, 0, 0, 3'b000, 32'h100, 32'h180, 32'h0, 0, 1, 0, 0);
        cycle();
        check("beq_rv", {31'b0, bus.redirect_valid}, 32'd1);
        check("beq_rpc", bus.redirect_pc, 32'h180);
        check("beq_bc", bus.branch_count, 32'd1);
        check("beq_mc", bus.mispredict_count, 32'd1);
        bus.if_pc = 32'h100;
        #1;
        check("beq_pred", {31'b0, bus.if_pred_taken}, 32'd1);
        idle();
        cycle();

        // BGEU not taken, predicted not-taken
        drive(1, 1, 0, 0, 3'b111, 32'h200, 32'h280, 32'h0, 0, 0, 0, 1);
        cycle();
        check("bgeu_rv", {31'b0, bus.redirect_valid}, 32'd0);
        check("bgeu_bc", bus.branch_count, 32'd2);
        check("bgeu_mc", bus.mispredict_count, 32'd1);
        #1;
        check("bgeu_pred", {31'b0, bus.if_pred_taken}, 32'd0);

        // Saturation: four taken, then one not-taken
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 0, 3'b000, 32'h100, 32'h180, 32'h0, 0, 1, 0, 0);
            cycle();
            idle();
            cycle();
        end
        drive(1, 1, 0, 0, 3'b000, 32'h100, 32'h180, 32'h0, 1, 0, 0, 0);
        cycle();
        check("sat_rpc", bus.redirect_pc, 32'h104);
        idle();
        #1;
        check("sat_pred", {31'b0, bus.if_pred_taken}, 32'd1);
        cycle();

        // JALR followed by a wrong-path BEQ mispredict
        drive(1, 0, 0, 1, 3'b000, 32'h300, 32'h0, 32'h1235, 0, 0, 0, 0);
        cycle();
        check("jalr_rpc", bus.redirect_pc, 32'h1234);
        drive(1, 1, 0, 0, 3'b000, 32'h104, 32'h500, 32'h0, 0, 1, 0, 0);
        cycle();
        check("squash_rv", {31'b0, bus.redirect_valid}, 32'd0);
        check("squash_rpc", bus.redirect_pc, 32'h1234);

        // Illegal funct3
        drive(1, 1, 0, 0, 3'b010, 32'h108, 32'h600, 32'h0, 0, 1, 1, 1);
        cycle();
        check("illegal_rv", {31'b0, bus.redirect_valid}, 32'd0);

        // Reset coincident with a mispredicting BNE
        drive(1, 1, 0, 0, 3'b001, 32'h10C, 32'h700, 32'h0, 0, 0, 0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rstbne_rv", {31'b0, bus.redirect_valid}, 32'd0);
        check("rstbne_bc", bus.branch_count, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            bit kind_jalr, kind_jal;
            kind_jalr = ($urandom_range(0, 9) == 0);
            kind_jal  = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, kind_jal, kind_jalr,
                  3'($urandom), {24'h0, 6'($urandom), 2'b00}, $urandom, $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            bus.if_pc = {24'h0, 6'($urandom), 2'($urandom)};
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage consumer of the branch comparator flags (br_eq, br_lt, br_ltu).
- Decodes funct3 to resolve conditional branches and handles JAL/JALR.
- Compares each outcome against the fetch-time prediction and issues a registered one-cycle PC redirect on mispredict or jump.
- Maintains a 2-bit saturating branch history table (BHT) that the fetch stage reads for predictions, plus branch and mispredict statistics counters.

Parameters:
BHT_IDX_W, 4, BHT index width; table holds 2**BHT_IDX_W 2-bit counters, indexed by pc[BHT_IDX_W+1:2]

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
ex_valid  input  1  EX stage holds a valid instruction
ex_is_branch  input  1  EX instruction is B-type
ex_is_jal  input  1  EX instruction is JAL
ex_is_jalr  input  1  EX instruction is JALR
ex_funct3  input  3  B-type funct3
ex_pc  input  32  PC of EX instruction
ex_br_target  input  32  pc+imm target (branch/JAL)
ex_jalr_target  input  32  rs1+imm (JALR, unmasked)
ex_pred_taken  input  1  prediction carried from fetch for this instruction
br_eq  input  1  rs1 == rs2
br_lt  input  1  signed rs1 < rs2
br_ltu  input  1  unsigned rs1 < rs2
if_pc  input  32  current fetch PC
if_pred_taken  output  1  combinational: MSB of BHT[if_pc index]
redirect_valid  output  1  registered one-cycle redirect/flush pulse
redirect_pc  output  32  registered redirect address
branch_count  output  32  resolved conditional branches
mispredict_count  output  32  mispredicted conditional branches

Behaviour:
- Squash: when redirect_valid=1 in a cycle, that cycle's EX inputs are wrong-path.
  - No BHT update, no counter update, no new redirect.
  - redirect_valid therefore never stays high for two consecutive cycles.
- Active: act = ex_valid & ~redirect_valid & ~rst.
- Type priority when multiple flags are set: jalr > jal > branch.
- funct3 decode (taken):
  - 000 eq; 001 ~eq; 100 lt; 101 ~lt; 110 ltu; 111 ~ltu.
  - 010/011 are illegal: not taken, no BHT update, no count, no redirect.
- JALR: at the next edge, redirect_valid<=1 and redirect_pc<=ex_jalr_target with bit0 cleared. Counters and BHT are untouched.
- JAL: at the next edge, redirect_valid<=1 and redirect_pc<=ex_br_target. Counters and BHT are untouched.
- Legal conditional branch:
  - Mispredict = taken != ex_pred_taken.
  - On mispredict: redirect_valid<=1; redirect_pc<=ex_br_target if taken, else ex_pc+4 (32-bit wrap).
  - branch_count += 1.
  - mispredict_count += 1 on mispredict.
  - Both counters wrap modulo 2**32.
- Otherwise: redirect_valid<=0 and redirect_pc holds its previous value.
- Latency: EX resolve to redirect_valid is exactly 1 cycle.
- BHT counter update on a legal active branch:
  - taken: saturating increment, 11 stays 11.
  - not taken: saturating decrement, 00 stays 00.
- BHT read/write timing:
  - if_pred_taken is a pure combinational read of the current table.
  - A same-cycle write to the same index is not bypassed; the old value is seen.
  - A write becomes visible the cycle after the edge.
- Reset (synchronous, dominates all other inputs):
  - redirect_valid=0, redirect_pc=0, branch_count=0, mispredict_count=0.
  - Every BHT entry = 01 (weakly not-taken), so if_pred_taken=0 after reset.
- Reset mid-operation: a redirect pending from the reset-cycle EX instruction is discarded.

Test Plan:
- Reset, then if_pc=0x40 -> if_pred_taken=0; counters 0; redirect_valid=0.
- BEQ (funct3 000), br_eq=1, ex_pred_taken=0, ex_pc=0x100, ex_br_target=0x180 -> next cycle:
  - redirect_valid=1, redirect_pc=0x180.
  - branch_count=1, mispredict_count=1.
  - BHT[idx 0] = 10, and if_pc=0x100 reads if_pred_taken=1.
- BGEU (111), br_ltu=1, ex_pred_taken=0, ex_pc=0x200 -> no redirect; branch_count increments; mispredict_count unchanged; BHT[0] decrements.
- Same-index branch taken 4 times back-to-back, with a cycle gap after each redirect -> counter saturates at 11; a further not-taken moves it to 10, and if_pred_taken stays 1.
- JALR, ex_jalr_target=0x1235, with BEQ mispredict in the following cycle -> redirect_pc=0x1234 for one cycle; the following BEQ is squashed (no redirect, counters unchanged).
- Combined reset cases:
  - funct3=010 with ex_valid=1 -> no redirect, no count.
  - rst=1 coincident with a mispredicting BNE -> redirect_valid=0 next cycle, counters 0.
